// File: rtl/sram_1rw1r_model.sv
// Parametrised single-clock 1RW+1R synchronous memory model.
// Drop-in for the 32x512 hard macro's port behaviour, with zero-fill sweep.
//
// Ports:
//   clk0       single clock, all sampling on posedge
//   rstb       asynchronous active-low reset
//   init_done  high once the array is accessible
//   csb0/web0  port 0 active-low select / write enable
//   wmask0     port 0 per-lane write enable (active high)
//   addr0/din0 port 0 address / write data
//   dout0      port 0 read data
//   csb1/addr1 port 1 active-low select / address (read only)
//   dout1      port 1 read data
//   collision  one-cycle flag, same-address write/read on the same edge,
//              aligned with the matching dout1 update
module sram_1rw1r_model #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 9,
    parameter int WMASK_WIDTH    = 8,
    parameter int READ_LATENCY   = 1,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                                clk0,
    input  logic                                rstb,
    output logic                                init_done,
    input  logic                                csb0,
    input  logic                                web0,
    input  logic [DATA_WIDTH/WMASK_WIDTH-1:0]   wmask0,
    input  logic [ADDR_WIDTH-1:0]               addr0,
    input  logic [DATA_WIDTH-1:0]               din0,
    output logic [DATA_WIDTH-1:0]               dout0,
    input  logic                                csb1,
    input  logic [ADDR_WIDTH-1:0]               addr1,
    output logic [DATA_WIDTH-1:0]               dout1,
    output logic                                collision
);

    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    localparam int NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    // Storage is deliberately not reset; only the sweep clears it.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] cnt_d;
    logic                  sweep_we;

    logic                  ready;
    logic                  wr0;
    logic                  rd0;
    logic                  rd1;
    logic                  hit;
    logic [DATA_WIDTH-1:0] old0;
    logic [DATA_WIDTH-1:0] old1;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] rd1_data;

    logic [DATA_WIDTH-1:0] d0_s1;
    logic [DATA_WIDTH-1:0] d1_s1;
    logic                  col_s1;
    logic                  init_q;

    // ------------------------------------------------------------------
    // Sweep FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk0 or negedge rstb) begin
        if (!rstb) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sweep_we = 1'b0;
        unique case (state_q)
            CLEAR: begin
                sweep_we = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

    // init_done follows the state the FSM enters on this edge, so it
    // rises on the edge that completes the sweep (or the first edge
    // after release when no sweep is configured).
    always_ff @(posedge clk0 or negedge rstb) begin
        if (!rstb) begin
            init_q <= 1'b0;
        end else begin
            init_q <= (state_d == READY);
        end
    end

    assign init_done = init_q;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign ready = (state_q == READY);
    assign wr0   = ready && !csb0 && !web0;
    assign rd0   = ready && !csb0 &&  web0;
    assign rd1   = ready && !csb1;
    assign hit   = wr0 && rd1 && (addr0 == addr1);

    assign old0 = mem[addr0];
    assign old1 = mem[addr1];

    // Word as it will look after the masked write.
    always_comb begin
        merged = old0;
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if (wmask0[i]) begin
                merged[i*WMASK_WIDTH +: WMASK_WIDTH] =
                    din0[i*WMASK_WIDTH +: WMASK_WIDTH];
            end
        end
    end

    assign rd1_data = (BYPASS != 0 && hit) ? merged : old1;

    // ------------------------------------------------------------------
    // Array write: sweep has priority, user writes only in READY
    // ------------------------------------------------------------------
    always_ff @(posedge clk0) begin
        if (sweep_we) begin
            mem[cnt_q] <= '0;
        end else if (wr0) begin
            mem[addr0] <= merged;
        end
    end

    // ------------------------------------------------------------------
    // Read stage 1
    // ------------------------------------------------------------------
    always_ff @(posedge clk0 or negedge rstb) begin
        if (!rstb) begin
            d0_s1  <= '0;
            d1_s1  <= '0;
            col_s1 <= 1'b0;
        end else begin
            if (rd0) begin
                d0_s1 <= old0;
            end
            if (rd1) begin
                d1_s1 <= rd1_data;
            end
            col_s1 <= hit;
        end
    end

    // ------------------------------------------------------------------
    // Optional stage 2: plain copy of stage 1, so holds propagate
    // ------------------------------------------------------------------
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] d0_s2;
            logic [DATA_WIDTH-1:0] d1_s2;
            logic                  col_s2;

            always_ff @(posedge clk0 or negedge rstb) begin
                if (!rstb) begin
                    d0_s2  <= '0;
                    d1_s2  <= '0;
                    col_s2 <= 1'b0;
                end else begin
                    d0_s2  <= d0_s1;
                    d1_s2  <= d1_s1;
                    col_s2 <= col_s1;
                end
            end

            assign dout0     = d0_s2;
            assign dout1     = d1_s2;
            assign collision = col_s2;
        end else begin : g_lat1
            assign dout0     = d0_s1;
            assign dout1     = d1_s1;
            assign collision = col_s1;
        end
    endgenerate

endmodule

// File: tb/tb_sram_1rw1r_model.sv
// Self-checking bench for sram_1rw1r_model (default parameters).
// Reference model: plain word array plus expected-output registers.
module tb_sram_1rw1r_model;

    logic        clk0 = 1'b0;
    logic        rstb = 1'b0;
    logic        init_done;
    logic        csb0 = 1'b1;
    logic        web0 = 1'b1;
    logic [3:0]  wmask0 = '0;
    logic [8:0]  addr0 = '0;
    logic [31:0] din0 = '0;
    logic [31:0] dout0;
    logic        csb1 = 1'b1;
    logic [8:0]  addr1 = '0;
    logic [31:0] dout1;
    logic        collision;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] ref_mem [512];
    logic [31:0] exp_d0;
    logic [31:0] exp_d1;
    logic        exp_col;

    sram_1rw1r_model dut (
        .clk0      (clk0),
        .rstb      (rstb),
        .init_done (init_done),
        .csb0      (csb0),
        .web0      (web0),
        .wmask0    (wmask0),
        .addr0     (addr0),
        .din0      (din0),
        .dout0     (dout0),
        .csb1      (csb1),
        .addr1     (addr1),
        .dout1     (dout1),
        .collision (collision)
    );

    always #5 clk0 = ~clk0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        csb0   = 1'b1;
        web0   = 1'b1;
        csb1   = 1'b1;
        wmask0 = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;
        exp_d0  = '0;
        exp_d1  = '0;
        exp_col = 1'b0;
    endtask

    // Apply the current inputs to the model for one READY edge, then
    // advance the DUT by one edge and settle.
    task automatic model_edge();
        logic [31:0] m;
        m = ref_mem[addr0];
        for (int i = 0; i < 4; i++)
            if (wmask0[i]) m[i*8 +: 8] = din0[i*8 +: 8];
        exp_col = 1'b0;
        if (!csb0 && web0) exp_d0 = ref_mem[addr0];
        if (!csb1) begin
            exp_col = !csb0 && !web0 && (addr0 == addr1);
            exp_d1  = exp_col ? m : ref_mem[addr1];
        end
        if (!csb0 && !web0) ref_mem[addr0] = m;
        @(posedge clk0);
        #1;
    endtask

    task automatic test_reset();
        int early;
        int bad;
        idle();
        rstb = 1'b0;
        #3;
        total_cnt++;
        if (dout0 !== 32'h0) $display("FAIL rst_dout0 got=%h exp=0", dout0);
        else pass_cnt++;
        total_cnt++;
        if (dout1 !== 32'h0) $display("FAIL rst_dout1 got=%h exp=0", dout1);
        else pass_cnt++;
        total_cnt++;
        if (collision !== 1'b0) $display("FAIL rst_col got=%b exp=0", collision);
        else pass_cnt++;
        total_cnt++;
        if (init_done !== 1'b0) $display("FAIL rst_init got=%b exp=0", init_done);
        else pass_cnt++;
        #5;
        rstb  = 1'b1;
        csb0  = 1'b0;
        web0  = 1'b1;
        addr0 = 9'd5;
        early = 0;
        bad   = 0;
        for (int e = 1; e <= 512; e++) begin
            @(posedge clk0);
            #1;
            if (e < 512 && init_done !== 1'b0) early++;
            if (dout0 !== 32'h0) bad++;
        end
        idle();
        total_cnt++;
        if (early != 0) $display("FAIL sweep_init_early edges=%0d exp=0", early);
        else pass_cnt++;
        total_cnt++;
        if (bad != 0) $display("FAIL sweep_dout0_hold edges=%0d exp=0", bad);
        else pass_cnt++;
        total_cnt++;
        if (init_done !== 1'b1) $display("FAIL sweep_init_512 got=%b exp=1", init_done);
        else pass_cnt++;
        model_clear();
    endtask

    task automatic test_sweep_reads();
        csb0 = 1'b0; web0 = 1'b1; addr0 = 9'd0;
        csb1 = 1'b0; addr1 = 9'd511;
        model_edge();
        total_cnt++;
        if (dout0 !== 32'h0) $display("FAIL clr_rd0_a0 got=%h exp=0", dout0);
        else pass_cnt++;
        total_cnt++;
        if (dout1 !== 32'h0) $display("FAIL clr_rd1_a511 got=%h exp=0", dout1);
        else pass_cnt++;
        addr0 = 9'd511; addr1 = 9'd0;
        model_edge();
        total_cnt++;
        if (dout0 !== 32'h0) $display("FAIL clr_rd0_a511 got=%h exp=0", dout0);
        else pass_cnt++;
        total_cnt++;
        if (dout1 !== 32'h0) $display("FAIL clr_rd1_a0 got=%h exp=0", dout1);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_masked_write();
        idle();
        csb0 = 1'b0; web0 = 1'b0; addr0 = 9'd3;
        din0 = 32'hAABBCCDD; wmask0 = 4'b1111;
        model_edge();
        din0 = 32'h11223344; wmask0 = 4'b0101;
        model_edge();
        total_cnt++;
        if (dout0 !== 32'h0) $display("FAIL wr_dout0_hold got=%h exp=0", dout0);
        else pass_cnt++;
        web0 = 1'b1; wmask0 = '0;
        model_edge();
        total_cnt++;
        if (dout0 !== 32'hAA22CC44)
            $display("FAIL mask_rd got=%h exp=%h", dout0, 32'hAA22CC44);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_collision();
        idle();
        csb0 = 1'b0; web0 = 1'b0; addr0 = 9'd7;
        din0 = 32'hDEADBEEF; wmask0 = 4'b0011;
        csb1 = 1'b0; addr1 = 9'd7;
        model_edge();
        total_cnt++;
        if (dout1 !== 32'h0000BEEF)
            $display("FAIL coll_bypass got=%h exp=%h", dout1, 32'h0000BEEF);
        else pass_cnt++;
        total_cnt++;
        if (collision !== 1'b1) $display("FAIL coll_flag got=%b exp=1", collision);
        else pass_cnt++;
        idle();
        model_edge();
        total_cnt++;
        if (collision !== 1'b0) $display("FAIL coll_pulse got=%b exp=0", collision);
        else pass_cnt++;
        total_cnt++;
        if (dout1 !== 32'h0000BEEF)
            $display("FAIL coll_hold got=%h exp=%h", dout1, 32'h0000BEEF);
        else pass_cnt++;
    endtask

    task automatic test_hold();
        int bad;
        idle();
        csb1 = 1'b0; addr1 = 9'd3;
        model_edge();
        total_cnt++;
        if (dout1 !== 32'hAA22CC44)
            $display("FAIL hold_rd1 got=%h exp=%h", dout1, 32'hAA22CC44);
        else pass_cnt++;
        csb1 = 1'b1;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            addr1 = 9'($urandom_range(0, 511));
            model_edge();
            if (dout1 !== 32'hAA22CC44 || collision !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad != 0) $display("FAIL hold_csb1 cycles=%0d dout1=%h", bad, dout1);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            csb0   = ($urandom_range(0, 3) == 0);
            web0   = $urandom_range(0, 1) != 0;
            wmask0 = 4'($urandom_range(0, 15));
            addr0  = 9'($urandom_range(0, 7));
            din0   = $urandom;
            csb1   = ($urandom_range(0, 3) == 0);
            addr1  = 9'($urandom_range(0, 7));
            model_edge();
            total_cnt++;
            if (dout0 !== exp_d0)
                $display("FAIL rnd_dout0 k=%0d got=%h exp=%h", k, dout0, exp_d0);
            else pass_cnt++;
            total_cnt++;
            if (dout1 !== exp_d1)
                $display("FAIL rnd_dout1 k=%0d got=%h exp=%h", k, dout1, exp_d1);
            else pass_cnt++;
            total_cnt++;
            if (collision !== exp_col)
                $display("FAIL rnd_col k=%0d got=%b exp=%b", k, collision, exp_col);
            else pass_cnt++;
        end
        idle();
    endtask

    task automatic test_reset_midsweep();
        int n;
        idle();
        csb0 = 1'b0; web0 = 1'b0; addr0 = 9'd100;
        din0 = 32'h12345678; wmask0 = 4'b1111;
        model_edge();
        web0 = 1'b1; csb1 = 1'b0; addr1 = 9'd100;
        model_edge();
        idle();
        total_cnt++;
        if (dout0 !== 32'h12345678 || dout1 !== 32'h12345678)
            $display("FAIL pre_rst_rd got=%h/%h exp=%h", dout0, dout1, 32'h12345678);
        else pass_cnt++;
        rstb = 1'b0;
        #1;
        total_cnt++;
        if (dout0 !== 32'h0 || dout1 !== 32'h0)
            $display("FAIL async_rst_dout got=%h/%h exp=0", dout0, dout1);
        else pass_cnt++;
        total_cnt++;
        if (init_done !== 1'b0) $display("FAIL async_rst_init got=%b exp=0", init_done);
        else pass_cnt++;
        #2;
        rstb = 1'b1;
        repeat (200) @(posedge clk0);
        #1;
        total_cnt++;
        if (init_done !== 1'b0) $display("FAIL mid_sweep_init got=%b exp=0", init_done);
        else pass_cnt++;
        rstb = 1'b0;
        #2;
        rstb = 1'b1;
        n = 0;
        while (init_done !== 1'b1 && n < 600) begin
            @(posedge clk0);
            #1;
            n++;
        end
        total_cnt++;
        if (n != 512) $display("FAIL resweep_len edges=%0d exp=512", n);
        else pass_cnt++;
        model_clear();
        csb0 = 1'b0; web0 = 1'b1; addr0 = 9'd100;
        csb1 = 1'b0; addr1 = 9'd3;
        model_edge();
        total_cnt++;
        if (dout0 !== 32'h0 || dout1 !== 32'h0)
            $display("FAIL resweep_clear got=%h/%h exp=0", dout0, dout1);
        else pass_cnt++;
        idle();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_sweep_reads();
        test_masked_write();
        test_collision();
        test_hold();
        test_random();
        test_reset_midsweep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
